// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locking arbiter sharing one fifo write port.
// Optional feature: define FIFO_ARB_STATS_EN for per-requester saturating beat counters.
module fifo_wr_arbiter #(
  parameter int  N_REQ     = 4,
  parameter int  WIDTH     = 32,
  parameter int  MAX_BURST = 8,
  localparam int SRC_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wen,
  output logic [SRC_W+WIDTH:0]   fifo_wdata,
  output logic                   busy,
  output logic [SRC_W-1:0]       owner,
  output logic [N_REQ*16-1:0]    stat_beats
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_LOCK  = 1'b1;
  localparam logic [SRC_W:0]   N_REQ_X  = (SRC_W + 1)'(N_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [0:0]       state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0] grant_idle;
  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] win_idle;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] scan_idx;
  logic [SRC_W:0]   scan_sum;
  logic             scan_blocked;
  logic             w_last;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    if (idx == LAST_IDX) return '0;
    return idx + SRC_W'(1);
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Grant in IDLE only looks at requesters scanned before w, so a requester's
  // ready never depends on its own valid.
  always_comb begin
    grant_idle   = '0;
    win_idle     = rr_ptr_q;
    scan_blocked = 1'b0;
    scan_sum     = '0;
    scan_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
      if (scan_sum >= N_REQ_X) scan_sum = scan_sum - N_REQ_X;
      scan_idx = scan_sum[SRC_W-1:0];
      grant_idle[scan_idx] = ~scan_blocked;
      if (req_valid[scan_idx] && !scan_blocked) win_idle = scan_idx;
      scan_blocked = scan_blocked | req_valid[scan_idx];
    end
  end

  always_comb begin
    grant  = '0;
    winner = win_idle;
    if (state_q == ST_LOCK) begin
      grant[owner_q] = 1'b1;
      winner         = owner_q;
    end else begin
      grant = grant_idle;
    end
  end

  assign req_ready  = (rst || fifo_full) ? '0 : grant;
  assign fifo_wen   = |(req_valid & req_ready);
  assign w_last     = req_last[winner];
  assign fifo_wdata = {winner, w_last, data_arr[winner]};
  assign busy       = (state_q == ST_LOCK);
  assign owner      = owner_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (fifo_wen) begin
      if (state_q == ST_IDLE) begin
        owner_d = winner;
        if (w_last || MAX_BURST == 1) begin
          rr_ptr_d = next_idx(winner);
        end else begin
          state_d    = ST_LOCK;
          beat_cnt_d = CNT_ONE;
        end
      end else if (w_last || beat_cnt_q == CNT_LAST) begin
        // Forced release leaves the beat's last bit as the requester drove it.
        state_d    = ST_IDLE;
        rr_ptr_d   = next_idx(owner_q);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
    logic [15:0] beats_q, beats_d;

    always_comb begin
      beats_d = beats_q;
      if (req_valid[gi] && req_ready[gi] && beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
    end

    always_ff @(posedge clk) begin
      if (rst) beats_q <= '0;
      else     beats_q <= beats_d;
    end

    assign stat_beats[gi*16 +: 16] = beats_q;
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arbiter;
  localparam int N_REQ     = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;
  localparam int SRC_W     = 2;
  localparam int DW        = SRC_W + 1 + WIDTH;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_wen;
  logic [DW-1:0]          fifo_wdata;
  logic                   busy;
  logic [SRC_W-1:0]       owner;
  logic [N_REQ*16-1:0]    stat_beats;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .busy(busy),
    .owner(owner), .stat_beats(stat_beats)
  );

  // Every fifo write is matched against the next expected beat.
  always @(negedge clk) begin
    if (fifo_wen) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra_write got=%h expected=none", fifo_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wdata !== mon_exp) begin
          n_err++;
          $display("FAIL scoreboard_wdata got=%h expected=%h", fifo_wdata, mon_exp);
        end else begin
          $display("write src=%0d last=%0d data=%h", fifo_wdata[DW-1 -: SRC_W],
                   fifo_wdata[WIDTH], fifo_wdata[WIDTH-1:0]);
        end
      end
    end
  end

  function automatic logic [DW-1:0] beat(input int src, input bit last, input logic [31:0] d);
    return {SRC_W'(src), last, d};
  endfunction

  task automatic drive(input int i, input bit v, input bit l, input logic [31:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    rst = 1'b1;
    req_valid = '1;
    req_last  = '1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b expected=0000", req_ready); end
    n_vec++;
    if (fifo_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b expected=0", fifo_wen); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b expected=0", busy); end
    n_vec++;
    if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got=%0d expected=0", owner); end
    n_vec++;
    if (stat_beats !== '0) begin n_err++; $display("FAIL reset_stats got=%h expected=0", stat_beats); end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, 1'b1, 32'h1000_0000 + 32'(i*256 + c));
      exp_q.push_back(beat(c % 4, 1'b1, 32'h1000_0000 + 32'((c % 4)*256 + c)));
      @(negedge clk);
      n_vec++;
      if (fifo_wen !== 1'b1) begin n_err++; $display("FAIL rr_wen cycle=%0d got=%b expected=1", c, fifo_wen); end
    end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_locked_packet();
    logic [31:0] pkt [3];
    pkt[0] = 32'hAAAA_0001; pkt[1] = 32'hBBBB_0002; pkt[2] = 32'hCCCC_0003;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, c == 2, pkt[c]);
      drive(1, 1'b1, 1'b1, 32'hD1D1_0000);
      exp_q.push_back(beat(0, c == 2, pkt[c]));
      @(negedge clk);
      if (c > 0) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL lock_busy beat=%0d got=%b expected=1", c, busy); end
        n_vec++;
        if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL lock_ready1 beat=%0d got=%b expected=0", c, req_ready[1]); end
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(beat(1, 1'b1, 32'hD1D1_0000));
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL unlock_busy got=%b expected=0", busy); end
    n_vec++;
    if (req_ready[1] !== 1'b1) begin n_err++; $display("FAIL unlock_ready1 got=%b expected=1", req_ready[1]); end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_forced_release();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(2, 1'b1, 1'b0, 32'h2222_0000 + 32'(c));
      drive(3, 1'b1, 1'b1, 32'h3333_0000);
      exp_q.push_back(beat(2, 1'b0, 32'h2222_0000 + 32'(c)));
      @(negedge clk);
      if (c > 0) begin
        n_vec++;
        if (req_ready[3] !== 1'b0) begin n_err++; $display("FAIL burst_ready3 beat=%0d got=%b expected=0", c, req_ready[3]); end
      end
    end
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 32'h2222_0004);
    exp_q.push_back(beat(3, 1'b1, 32'h3333_0000));
    @(negedge clk);
    n_vec++;
    if (req_ready[2] !== 1'b0) begin n_err++; $display("FAIL release_ready2 got=%b expected=0", req_ready[2]); end
    for (int c = 4; c < 7; c++) begin
      @(posedge clk); #1;
      drive(2, 1'b1, c == 6, 32'h2222_0000 + 32'(c));
      exp_q.push_back(beat(2, c == 6, 32'h2222_0000 + 32'(c)));
      @(negedge clk);
    end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_fifo_full();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      fifo_full = (c >= 2 && c <= 4);
      if (c >= 2) drive(0, 1'b1, 1'b1, 32'hF0F0_0000);
      drive(1, 1'b1, 1'b0, 32'h1111_0000 + 32'(c < 2 ? c : (c < 5 ? 2 : c - 3)));
      if (c < 2 || c > 4) exp_q.push_back(beat(1, 1'b0, 32'h1111_0000 + 32'(c < 2 ? c : c - 3)));
      @(negedge clk);
      if (fifo_full) begin
        n_vec++;
        if (fifo_wen !== 1'b0) begin n_err++; $display("FAIL full_wen cycle=%0d got=%b expected=0", c, fifo_wen); end
        n_vec++;
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL full_ready cycle=%0d got=%b expected=0000", c, req_ready); end
        n_vec++;
        if (busy !== 1'b1 || owner !== 2'd1) begin
          n_err++; $display("FAIL full_hold cycle=%0d got busy=%b owner=%0d expected busy=1 owner=1", c, busy, owner);
        end
      end
    end
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(beat(0, 1'b1, 32'hF0F0_0000));
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL full_release_busy got=%b expected=0", busy); end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive(3, 1'b1, 1'b0, 32'h3030_0000 + 32'(c));
      exp_q.push_back(beat(3, 1'b0, 32'h3030_0000 + 32'(c)));
      @(negedge clk);
    end
    n_vec++;
    if (busy !== 1'b1 || owner !== 2'd3) begin
      n_err++; $display("FAIL midburst_lock got busy=%b owner=%0d expected busy=1 owner=3", busy, owner);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b1, 32'h4040_0000 + 32'(i));
    drive(3, 1'b1, 1'b0, 32'h3030_0002);
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b0000 || fifo_wen !== 1'b0) begin
      n_err++; $display("FAIL midburst_rst_gate got ready=%b wen=%b expected ready=0000 wen=0", req_ready, fifo_wen);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(beat(0, 1'b1, 32'h4040_0000));
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      n_err++; $display("FAIL post_rst_state got busy=%b owner=%0d expected busy=0 owner=0", busy, owner);
    end
    n_vec++;
    if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL post_rst_ready0 got=%b expected=1", req_ready[0]); end
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic test_stats();
    logic [N_REQ*16-1:0] exp_stats;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (stat_beats !== '0) begin n_err++; $display("FAIL stats_cleared got=%h expected=0", stat_beats); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      drive(1, 1'b1, c == 4, 32'h5151_0000 + 32'(c));
      exp_q.push_back(beat(1, c == 4, 32'h5151_0000 + 32'(c)));
      @(negedge clk);
    end
    @(posedge clk); #1;
    clear_all();
    @(negedge clk);
`ifdef FIFO_ARB_STATS_EN
    exp_stats = {16'd0, 16'd0, 16'd5, 16'd0};
`else
    exp_stats = '0;
`endif
    n_vec++;
    if (stat_beats !== exp_stats) begin n_err++; $display("FAIL stats_count got=%h expected=%h", stat_beats, exp_stats); end
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    test_reset();
    test_round_robin();
    test_locked_packet();
    test_forced_release();
    test_fifo_full();
    test_reset_mid_burst();
    test_stats();
    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_pending got=%0d expected=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
